spi_reg_responder: RTL and testbench

SPI slave-side register responder: decodes command/address/data frames sent by `SPI_master` and serves reads and writes against an internal 8-bit register file. All SPI inputs are asynchronous to `i_clk`; they are synchronized and edge-detected internally, with no logic clocked on SCK. The block is the target-side endpoint used to exercise the master across all four CPOL/CPHA modes in system and bench runs.

---
 rtl/spi_reg_responder.sv | 190 +++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI target register responder: {rw,addr[6:0]} command byte, then data bytes; fully clocked on i_clk.
// Define SPI_RESP_BURST_EN to auto-increment the address on each byte after byte 1.
module spi_reg_responder #(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] RST_VAL = 8'h00,
  localparam int        AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpol,
  input  logic          i_cpha,
  input  logic          i_SCK_s,
  input  logic          i_CS_s,
  input  logic          i_MOSI_s,
  output logic          o_MISO_s,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_wr_stb,
  output logic [6:0]    o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_busy,
  output logic          o_err
);

`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sck_sync_q, cs_sync_q, mosi_sync_q;
  logic        sck_prev_q, cs_prev_q;
  logic        cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d, first_q, first_d;
  logic        wr_stb_q, wr_stb_d, err_q, err_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q;
  logic [7:0]  regs_q [DEPTH];

  logic        sck_s, cs_s, mosi_s, sck_edge, lead, trail, sample, drive, cs_fall, cs_rise;
  logic [7:0]  rx_byte, rd_val;
  logic [6:0]  addr_inc, rd_a;
  logic        we;

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_edge = sck_s ^ sck_prev_q;
  assign lead     = sck_edge && (sck_prev_q == cpol_q);
  assign trail    = sck_edge && (sck_prev_q != cpol_q);
  assign sample   = cpha_q ? trail : lead;
  assign drive    = cpha_q ? lead : trail;
  assign cs_fall  = !cs_s && cs_prev_q;
  assign cs_rise  = cs_s && !cs_prev_q;
  assign rx_byte  = {rx_q, mosi_s};
  assign addr_inc = addr_q + 7'd1;
  // Only one register lookup is ever needed per cycle: the command address or the next burst address.
  assign rd_a     = (state_q == CMD) ? rx_byte[6:0] : addr_inc;
  assign rd_val   = (int'(rd_a) < DEPTH) ? regs_q[rd_a[AW-1:0]] : 8'h00;

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    first_d   = first_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    we        = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d   = CMD;
        cpol_d    = i_cpol;
        cpha_d    = i_cpha;
        bit_cnt_d = 3'd0;
        tx_d      = 8'h00;
        miso_d    = 1'b0;
      end
    end else begin
      if (sample) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == CMD) begin
            state_d = DATA;
            rw_d    = rx_byte[7];
            addr_d  = rx_byte[6:0];
            first_d = 1'b1;
            tx_d    = rx_byte[7] ? rd_val : 8'h00;
          end else begin
            first_d = 1'b0;
            tx_d    = (BURST && rw_q) ? rd_val : 8'h00;
            if (BURST) addr_d = addr_inc;
            if ((first_q || BURST) && !rw_q) begin
              we        = int'(addr_q) < DEPTH;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_byte;
            end
          end
        end
      end
      if (drive) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      // A byte completing in this same cycle has already committed above and wrapped the counter.
      if (cs_rise) begin
        state_d = IDLE;
        miso_d  = 1'b0;
        tx_d    = 8'h00;
        err_d   = (bit_cnt_d != 3'd0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // CS sync resets "low" so a frame already in flight never produces a falling edge.
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= RST_VAL;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], i_SCK_s};
      cs_sync_q   <= {cs_sync_q[0], i_CS_s};
      mosi_sync_q <= {mosi_sync_q[0], i_MOSI_s};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      rd_data_q   <= (int'(i_rd_addr) < DEPTH) ? regs_q[i_rd_addr] : 8'h00;
      if (we) regs_q[addr_q[AW-1:0]] <= rx_byte;
    end
  end

  assign o_MISO_s  = miso_q;
  assign o_rd_data = rd_data_q;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = (state_q != IDLE);
  assign o_err     = err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench: a behavioural SPI master drives two responders (DEPTH 16 and DEPTH 128) on shared pins.
module tb_spi_reg_responder;
`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int H = 8;

  logic clk = 1'b0, rst = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic [3:0] ra16 = '0;
  logic [6:0] ra128 = '0;
  logic       miso16, stb16, busy16, err16, miso128, stb128, busy128, err128;
  logic [7:0] rd16_o, wd16, rd128_o, wd128;
  logic [6:0] wa16, wa128;

  int n_chk = 0, n_fail = 0;
  int wr_cnt16 = 0, wr_cnt128 = 0, err_cnt16 = 0;
  logic [6:0] last_wa16;
  logic [7:0] last_wd16, rd_at_stb, rd_after;
  logic       prev_stb16 = 1'b0, busy_after_rst;
  logic [7:0] mtx [4];
  logic [7:0] mrx [4];

  always #5 clk = ~clk;

  spi_reg_responder #(.DEPTH(16), .RST_VAL(8'h00)) u16 (
    .i_clk(clk), .i_rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_SCK_s(sck), .i_CS_s(cs),
    .i_MOSI_s(mosi), .o_MISO_s(miso16), .i_rd_addr(ra16), .o_rd_data(rd16_o), .o_wr_stb(stb16),
    .o_wr_addr(wa16), .o_wr_data(wd16), .o_busy(busy16), .o_err(err16));

  spi_reg_responder #(.DEPTH(128), .RST_VAL(8'h3C)) u128 (
    .i_clk(clk), .i_rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_SCK_s(sck), .i_CS_s(cs),
    .i_MOSI_s(mosi), .o_MISO_s(miso128), .i_rd_addr(ra128), .o_rd_data(rd128_o), .o_wr_stb(stb128),
    .o_wr_addr(wa128), .o_wr_data(wd128), .o_busy(busy128), .o_err(err128));

  always @(negedge clk) begin
    if (prev_stb16) rd_after = rd16_o;
    if (stb16) begin
      wr_cnt16++;
      last_wa16 = wa16;
      last_wd16 = wd16;
      rd_at_stb = rd16_o;
    end
    prev_stb16 = stb16;
    if (stb128) wr_cnt128++;
    if (err16) err_cnt16++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd16(input logic [3:0] a, output logic [7:0] d);
    ra16 = a;
    repeat (2) @(negedge clk);
    d = rd16_o;
  endtask

  task automatic rd128(input logic [6:0] a, output logic [7:0] d);
    ra128 = a;
    repeat (2) @(negedge clk);
    d = rd128_o;
  endtask

  // nbits may stop short of a byte; rst_bit >= 0 pulses reset before that bit; cs_last raises CS on the last sample edge.
  task automatic spi_frame(input logic pol, input logic pha, input int nbits, input int rst_bit, input bit cs_last);
    logic [7:0] cur;
    cpol = pol; cpha = pha; sck = pol; mosi = 1'b0; cs = 1'b1;
    for (int k = 0; k < 4; k++) mrx[k] = 8'h00;
    repeat (H) @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cur = mtx[i/8];
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        busy_after_rst = busy16;
      end
      if (!pha) begin
        mosi = cur[7 - (i%8)];
        repeat (H) @(negedge clk);
        sck = ~pol;
        mrx[i/8][7 - (i%8)] = miso16;
        if (cs_last && i == nbits - 1) cs = 1'b1;
        repeat (H) @(negedge clk);
        sck = pol;
      end else begin
        sck = ~pol;
        mosi = cur[7 - (i%8)];
        repeat (H) @(negedge clk);
        sck = pol;
        mrx[i/8][7 - (i%8)] = miso16;
        if (cs_last && i == nbits - 1) cs = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (rd16_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd16: got %h want 00", rd16_o); end
    n_chk++; if (rd128_o !== 8'h3C) begin n_fail++; $display("FAIL reset_rd128: got %h want 3c", rd128_o); end
    n_chk++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy16); end
    n_chk++; if (miso16 !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso16); end
    n_chk++; if ({stb16, err16} !== 2'b00) begin n_fail++; $display("FAIL reset_stb_err: got %b want 00", {stb16, err16}); end
    n_chk++; if ({wa16, wd16} !== 15'h0) begin n_fail++; $display("FAIL reset_wr_bus: got %h want 0", {wa16, wd16}); end
  endtask

  task automatic test_write_mode0();
    int c0;
    logic [7:0] d;
    ra16 = 4'd5;
    c0 = wr_cnt16;
    mtx[0] = 8'h05; mtx[1] = 8'hAB;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    n_chk++; if (wr_cnt16 - c0 !== 1) begin n_fail++; $display("FAIL wr_stb_count: got %0d want 1", wr_cnt16 - c0); end
    n_chk++; if (last_wa16 !== 7'h05) begin n_fail++; $display("FAIL wr_addr: got %h want 05", last_wa16); end
    n_chk++; if (last_wd16 !== 8'hAB) begin n_fail++; $display("FAIL wr_data: got %h want ab", last_wd16); end
    n_chk++; if (rd_at_stb !== 8'h00) begin n_fail++; $display("FAIL rd_same_cycle_old: got %h want 00", rd_at_stb); end
    n_chk++; if (rd_after !== 8'hAB) begin n_fail++; $display("FAIL rd_next_cycle_new: got %h want ab", rd_after); end
    rd16(4'd5, d);
    n_chk++; if (d !== 8'hAB) begin n_fail++; $display("FAIL wr_readback: got %h want ab", d); end
  endtask

  task automatic test_read_modes();
    int c0;
    mtx[0] = 8'h03; mtx[1] = 8'h5A;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    c0 = wr_cnt16;
    for (int m = 0; m < 4; m++) begin
      mtx[0] = 8'h83; mtx[1] = 8'h00;
      spi_frame(m[1], m[0], 16, -1, 1'b0);
      n_chk++; if (mrx[0] !== 8'h00) begin n_fail++; $display("FAIL read_byte0 mode%0d: got %h want 00", m, mrx[0]); end
      n_chk++; if (mrx[1] !== 8'h5A) begin n_fail++; $display("FAIL read_byte1 mode%0d: got %h want 5a", m, mrx[1]); end
    end
    n_chk++; if (wr_cnt16 !== c0) begin n_fail++; $display("FAIL read_no_write: got %0d strobes want 0", wr_cnt16 - c0); end
  endtask

  task automatic test_burst();
    int c0;
    logic [7:0] d;
    do_reset();
    c0 = wr_cnt128;
    mtx[0] = 8'h7F; mtx[1] = 8'h11; mtx[2] = 8'h22;
    spi_frame(1'b0, 1'b0, 24, -1, 1'b0);
    rd128(7'h7F, d);
    n_chk++; if (d !== 8'h11) begin n_fail++; $display("FAIL burst_reg127: got %h want 11", d); end
    rd128(7'h00, d);
    n_chk++; if (d !== (BURST ? 8'h22 : 8'h3C)) begin n_fail++; $display("FAIL burst_reg0: got %h want %h", d, BURST ? 8'h22 : 8'h3C); end
    n_chk++; if (wr_cnt128 - c0 !== (BURST ? 2 : 1)) begin n_fail++; $display("FAIL burst_stb_count: got %0d want %0d", wr_cnt128 - c0, BURST ? 2 : 1); end
  endtask

  task automatic test_out_of_range();
    int c0;
    logic [7:0] d;
    do_reset();
    mtx[0] = 8'h00; mtx[1] = 8'h77;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    c0 = wr_cnt16;
    mtx[0] = 8'h20; mtx[1] = 8'hFF;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    n_chk++; if (wr_cnt16 - c0 !== 1) begin n_fail++; $display("FAIL oor_stb_count: got %0d want 1", wr_cnt16 - c0); end
    n_chk++; if ({last_wa16, last_wd16} !== {7'h20, 8'hFF}) begin n_fail++; $display("FAIL oor_wr_bus: got %h/%h want 20/ff", last_wa16, last_wd16); end
    rd16(4'd0, d);
    n_chk++; if (d !== 8'h77) begin n_fail++; $display("FAIL oor_reg0_kept: got %h want 77", d); end
    mtx[0] = 8'hA0; mtx[1] = 8'h00;
    spi_frame(1'b1, 1'b1, 16, -1, 1'b0);
    n_chk++; if (mrx[1] !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %h want 00", mrx[1]); end
  endtask

  task automatic test_abort();
    int c0, e0;
    logic [7:0] d;
    mtx[0] = 8'h06; mtx[1] = 8'h99;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    c0 = wr_cnt16; e0 = err_cnt16;
    mtx[0] = 8'h06; mtx[1] = 8'hCC;
    spi_frame(1'b0, 1'b0, 13, -1, 1'b0);
    n_chk++; if (err_cnt16 - e0 !== 1) begin n_fail++; $display("FAIL abort_err_count: got %0d want 1", err_cnt16 - e0); end
    n_chk++; if (wr_cnt16 !== c0) begin n_fail++; $display("FAIL abort_no_stb: got %0d want 0", wr_cnt16 - c0); end
    rd16(4'd6, d);
    n_chk++; if (d !== 8'h99) begin n_fail++; $display("FAIL abort_reg_kept: got %h want 99", d); end
    n_chk++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy16); end
  endtask

  task automatic test_simultaneous();
    int c0, e0;
    logic [7:0] d;
    c0 = wr_cnt16; e0 = err_cnt16;
    mtx[0] = 8'h09; mtx[1] = 8'h3E;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b1);
    n_chk++; if (wr_cnt16 - c0 !== 1) begin n_fail++; $display("FAIL simul_stb_count: got %0d want 1", wr_cnt16 - c0); end
    n_chk++; if (err_cnt16 !== e0) begin n_fail++; $display("FAIL simul_no_err: got %0d want 0", err_cnt16 - e0); end
    rd16(4'd9, d);
    n_chk++; if (d !== 8'h3E) begin n_fail++; $display("FAIL simul_reg: got %h want 3e", d); end
  endtask

  task automatic test_reset_midframe();
    int c0;
    logic [7:0] d;
    mtx[0] = 8'h02; mtx[1] = 8'h44;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    c0 = wr_cnt16;
    mtx[0] = 8'h02; mtx[1] = 8'h55;
    spi_frame(1'b0, 1'b0, 16, 12, 1'b0);
    n_chk++; if (busy_after_rst !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_after_rst); end
    n_chk++; if (wr_cnt16 !== c0) begin n_fail++; $display("FAIL midrst_no_stb: got %0d want 0", wr_cnt16 - c0); end
    rd16(4'd2, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrst_reg16: got %h want 00", d); end
    rd128(7'h02, d);
    n_chk++; if (d !== 8'h3C) begin n_fail++; $display("FAIL midrst_reg128: got %h want 3c", d); end
    mtx[0] = 8'h02; mtx[1] = 8'h66;
    spi_frame(1'b0, 1'b0, 16, -1, 1'b0);
    rd16(4'd2, d);
    n_chk++; if (d !== 8'h66) begin n_fail++; $display("FAIL midrst_next_frame: got %h want 66", d); end
  endtask

  initial begin
    test_reset();
    test_write_mode0();
    test_read_modes();
    test_burst();
    test_out_of_range();
    test_abort();
    test_simultaneous();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
